// File: rtl/audio_pkg.sv
// Shared constants and helpers for the speaker output path.
package audio_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int VOL_W        = 3;
    localparam int DIV_W        = 10;
    localparam int FRAME_LEN    = 1024;
    localparam int SLOT_CLKS    = 16;
    localparam int SLOTS_PER_CH = 32;
    localparam int DATA_SLOT0   = 1;
    localparam int MCLK_BIT     = 1;
    localparam int SCK_BIT      = 3;
    localparam int LRCK_BIT     = 9;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Mute forces silence; otherwise attenuate by a sign-filling shift.
    function automatic sample_t scale_sample(input sample_t s,
                                             input logic m,
                                             input logic [VOL_W-1:0] v);
        return m ? sample_t'(0) : (s >>> v);
    endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// Free-running frame divider; the DAC clocks are plain register taps of it,
// so they cannot glitch.
module audio_clk_gen
    import audio_pkg::*;
(
    input  logic       clk_100mhz,
    input  logic       rst_n,
    output logic       audio_mclk,
    output logic       audio_sck,
    output logic       audio_lrck,
    output logic [5:0] frame_pos,
    output logic       frame_start,
    output logic       slot_start
);

    logic [DIV_W-1:0] div_cnt;

    // Count every clock, wrapping at the frame length.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign audio_mclk  = div_cnt[MCLK_BIT];
    assign audio_sck   = div_cnt[SCK_BIT];
    assign audio_lrck  = div_cnt[LRCK_BIT];
    // {half, slot} of the current SCK slot.
    assign frame_pos   = div_cnt[DIV_W-1:4];
    assign frame_start = &div_cnt;
    assign slot_start  = &div_cnt[3:0];

endmodule

// File: rtl/i2s_speaker_serializer.sv
// I2S output stage: latches a scaled L/R pair once per frame and shifts it
// out MSB first with the one-SCK I2S delay.
module i2s_speaker_serializer
    import audio_pkg::*;
(
    input  logic                clk_100mhz,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] audio_left,
    input  logic [SAMPLE_W-1:0] audio_right,
    input  logic                mute,
    input  logic [VOL_W-1:0]    volume,
    output logic                audio_mclk,
    output logic                audio_sck,
    output logic                audio_lrck,
    output logic                audio_sdin,
    output logic                sample_req
);

    logic [5:0] frame_pos;
    logic       frame_start;
    logic       slot_start;

    sample_t    lat_l;
    sample_t    lat_r;

    logic [5:0] pos_next;
    logic [4:0] slot_next;
    logic       half_next;
    sample_t    word_next;
    logic [3:0] bit_idx;
    logic       sdin_next;

    audio_clk_gen u_clk_gen (
        .clk_100mhz  (clk_100mhz),
        .rst_n       (rst_n),
        .audio_mclk  (audio_mclk),
        .audio_sck   (audio_sck),
        .audio_lrck  (audio_lrck),
        .frame_pos   (frame_pos),
        .frame_start (frame_start),
        .slot_start  (slot_start)
    );

    // Capture the scaled sample pair as the frame wraps; flag it one cycle later.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            lat_l      <= '0;
            lat_r      <= '0;
            sample_req <= 1'b0;
        end else begin
            sample_req <= frame_start;
            if (frame_start) begin
                lat_l <= scale_sample($signed(audio_left), mute, volume);
                lat_r <= scale_sample($signed(audio_right), mute, volume);
            end
        end
    end

    // Bit for the slot about to begin. Slot k carries bit 16-k, which
    // modulo 16 is simply -k on the low four slot bits.
    always_comb begin
        pos_next  = frame_pos + 6'd1;
        slot_next = pos_next[4:0];
        half_next = pos_next[5];
        word_next = half_next ? lat_r : lat_l;
        bit_idx   = 4'd0 - slot_next[3:0];
        sdin_next = 1'b0;
        if (slot_next >= 5'(DATA_SLOT0) && slot_next <= 5'(DATA_SLOT0 + SAMPLE_W - 1)) begin
            sdin_next = word_next[bit_idx];
        end
    end

    // Serial data moves on the SCK falling edge and holds for the whole slot.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            audio_sdin <= 1'b0;
        end else if (slot_start) begin
            audio_sdin <= sdin_next;
        end
    end

endmodule

// File: tb/tb_i2s_speaker_serializer.sv
// Testbench for the I2S speaker serializer.
module tb_i2s_speaker_serializer;

    logic        clk_100mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] audio_left = 16'h0;
    logic [15:0] audio_right = 16'h0;
    logic        mute = 1'b0;
    logic [2:0]  volume = 3'd0;
    logic        audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req;

    int n_checks = 0;
    int n_fail = 0;

    // n = clock edges since reset release; frame position is n mod 1024.
    int n = 0;
    logic [15:0] cur_l = 16'h0, cur_r = 16'h0, nxt_l = 16'h0, nxt_r = 16'h0;

    i2s_speaker_serializer dut (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .audio_left (audio_left),
        .audio_right(audio_right),
        .mute       (mute),
        .volume     (volume),
        .audio_mclk (audio_mclk),
        .audio_sck  (audio_sck),
        .audio_lrck (audio_lrck),
        .audio_sdin (audio_sdin),
        .sample_req (sample_req)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Attenuation as floor division by a power of two.
    function automatic logic [15:0] model_scale(input logic [15:0] s, input logic m, input int v);
        int x;
        int d;
        if (m) return 16'h0;
        x = int'($signed(s));
        d = 1 << v;
        if (x >= 0) x = x / d;
        else x = -((-x + d - 1) / d);
        return 16'(x);
    endfunction

    function automatic logic exp_sdin(input int p);
        int slot;
        logic [15:0] w;
        slot = (p / 16) % 32;
        w = ((p / 512) % 2 == 1) ? cur_r : cur_l;
        if (slot >= 1 && slot <= 16) return w[4'(16 - slot)];
        return 1'b0;
    endfunction

    task automatic tick();
        if (n % 1024 == 1023) begin
            nxt_l = model_scale(audio_left, mute, int'(volume));
            nxt_r = model_scale(audio_right, mute, int'(volume));
        end
        @(posedge clk_100mhz);
        #1;
        n++;
        if (n % 1024 == 0) begin
            cur_l = nxt_l;
            cur_r = nxt_r;
        end
    endtask

    task automatic model_reset();
        n = 0;
        cur_l = 16'h0; cur_r = 16'h0; nxt_l = 16'h0; nxt_r = 16'h0;
    endtask

    task automatic sync_frame();
        tick();
        while (n % 1024 != 0) tick();
    endtask

    task automatic capture_frame(input int chg_pos, input logic chg_mute, input logic [15:0] chg_left,
                                 output logic [15:0] wl, output logic [15:0] wr, output int stray);
        int p;
        int slot;
        while (n % 1024 != 0) tick();
        wl = 16'h0; wr = 16'h0; stray = 0;
        for (int i = 0; i < 1024; i++) begin
            p = n % 1024;
            if (p == chg_pos) begin
                mute = chg_mute;
                audio_left = chg_left;
            end
            if (p % 16 == 8) begin
                slot = (p / 16) % 32;
                if (slot >= 1 && slot <= 16) begin
                    if (p < 512) wl[4'(16 - slot)] = audio_sdin;
                    else         wr[4'(16 - slot)] = audio_sdin;
                end else if (audio_sdin !== 1'b0) begin
                    stray++;
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int first;
        int second;
        int p;
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk_100mhz);
            n_checks++;
            if ({audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected 00000",
                         {audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req});
            end
        end
        model_reset();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (sample_req !== 1'b0) begin
            n_fail++;
            $display("FAIL req_after_release: got %b expected 0", sample_req);
        end
        first = -1;
        for (int i = 0; i < 2000 && first < 0; i++) begin
            tick();
            p = n % 1024;
            n_checks++;
            if ({audio_mclk, audio_sck, audio_lrck} !== {1'((p / 2) % 2), 1'((p / 8) % 2), 1'((p / 512) % 2)}) begin
                n_fail++;
                $display("FAIL clock_taps: pos %0d got %b", p, {audio_mclk, audio_sck, audio_lrck});
            end
            if (sample_req === 1'b1) first = n;
        end
        n_checks++;
        if (first != 1024) begin
            n_fail++;
            $display("FAIL first_sample_req: got edge %0d expected 1024", first);
        end
        second = -1;
        for (int i = 0; i < 1100 && second < 0; i++) begin
            tick();
            if (sample_req === 1'b1) second = n;
        end
        n_checks++;
        if (second != 2048) begin
            n_fail++;
            $display("FAIL second_sample_req: got edge %0d expected 2048", second);
        end
    endtask

    task automatic test_pattern();
        logic [15:0] wl, wr;
        int stray;
        audio_left = 16'h1FFF; audio_right = 16'hE000; volume = 3'd0; mute = 1'b0;
        sync_frame();
        capture_frame(-1, 1'b0, 16'h1FFF, wl, wr, stray);
        n_checks++;
        if (wl !== 16'h1FFF) begin n_fail++; $display("FAIL pattern_left: got %h expected 1fff", wl); end
        n_checks++;
        if (wr !== 16'hE000) begin n_fail++; $display("FAIL pattern_right: got %h expected e000", wr); end
        n_checks++;
        if (stray != 0) begin n_fail++; $display("FAIL pattern_idle_slots: got %0d ones expected 0", stray); end
    endtask

    task automatic test_volume();
        logic [15:0] wl, wr;
        int stray;
        volume = 3'd1;
        sync_frame();
        capture_frame(-1, 1'b0, 16'h1FFF, wl, wr, stray);
        n_checks++;
        if (wl !== 16'h0FFF) begin n_fail++; $display("FAIL vol1_left: got %h expected 0fff", wl); end
        n_checks++;
        if (wr !== 16'hF000) begin n_fail++; $display("FAIL vol1_right: got %h expected f000", wr); end
        volume = 3'd7; audio_left = 16'h8000;
        sync_frame();
        capture_frame(-1, 1'b0, 16'h8000, wl, wr, stray);
        n_checks++;
        if (wl !== 16'hFF00) begin n_fail++; $display("FAIL vol7_left: got %h expected ff00", wl); end
        n_checks++;
        if (wr !== 16'hFFC0) begin n_fail++; $display("FAIL vol7_right: got %h expected ffc0", wr); end
    endtask

    task automatic test_mute();
        logic [15:0] wl, wr;
        int stray;
        audio_left = 16'h1FFF; audio_right = 16'hE000; volume = 3'd0; mute = 1'b0;
        sync_frame();
        capture_frame(300, 1'b1, 16'h1FFF, wl, wr, stray);
        n_checks++;
        if ({wl, wr} !== {16'h1FFF, 16'hE000}) begin
            n_fail++; $display("FAIL mute_current_frame: got %h %h expected 1fff e000", wl, wr);
        end
        capture_frame(-1, 1'b1, 16'h1FFF, wl, wr, stray);
        n_checks++;
        if ({wl, wr} !== 32'h0 || stray != 0) begin
            n_fail++; $display("FAIL mute_next_frame: got %h %h stray %0d expected 0", wl, wr, stray);
        end
        capture_frame(300, 1'b0, 16'h1FFF, wl, wr, stray);
        n_checks++;
        if ({wl, wr} !== 32'h0) begin
            n_fail++; $display("FAIL unmute_same_frame: got %h %h expected 0", wl, wr);
        end
        capture_frame(-1, 1'b0, 16'h1FFF, wl, wr, stray);
        n_checks++;
        if ({wl, wr} !== {16'h1FFF, 16'hE000}) begin
            n_fail++; $display("FAIL unmute_resume: got %h %h expected 1fff e000", wl, wr);
        end
    endtask

    task automatic test_sample_change();
        logic [15:0] wl, wr;
        int stray;
        capture_frame(200, 1'b0, 16'h5A5A, wl, wr, stray);
        n_checks++;
        if (wl !== 16'h1FFF) begin n_fail++; $display("FAIL midframe_left_held: got %h expected 1fff", wl); end
        capture_frame(-1, 1'b0, 16'h5A5A, wl, wr, stray);
        n_checks++;
        if (wl !== 16'h5A5A) begin n_fail++; $display("FAIL midframe_left_next: got %h expected 5a5a", wl); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] wl, wr;
        int stray;
        audio_left = 16'h1FFF; audio_right = 16'hE000;
        sync_frame();
        while (n % 1024 != 'h250) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req} !== 5'b0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got %b expected 00000",
                     {audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req});
        end
        model_reset();
        repeat (3) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        rst_n = 1'b1;
        capture_frame(-1, 1'b0, 16'h1FFF, wl, wr, stray);
        n_checks++;
        if ({wl, wr} !== 32'h0 || stray != 0) begin
            n_fail++; $display("FAIL post_reset_zero_frame: got %h %h stray %0d expected 0", wl, wr, stray);
        end
        capture_frame(-1, 1'b0, 16'h1FFF, wl, wr, stray);
        n_checks++;
        if ({wl, wr} !== {16'h1FFF, 16'hE000}) begin
            n_fail++; $display("FAIL post_reset_resume: got %h %h expected 1fff e000", wl, wr);
        end
    endtask

    task automatic test_random();
        int p;
        int chg;
        for (int f = 0; f < 12; f++) begin
            chg = int'($urandom_range(0, 1023));
            for (int i = 0; i < 1024; i++) begin
                p = n % 1024;
                if (p == chg) begin
                    audio_left  = 16'($urandom);
                    audio_right = 16'($urandom);
                    volume      = 3'($urandom_range(0, 7));
                    mute        = ($urandom_range(0, 3) == 0);
                end
                if (p % 16 == 8) begin
                    n_checks++;
                    if (audio_sdin !== exp_sdin(p)) begin
                        n_fail++;
                        $display("FAIL random_sdin: pos %0d got %b expected %b", p, audio_sdin, exp_sdin(p));
                    end
                end
                n_checks++;
                if (sample_req !== 1'(p == 0 && n > 0)) begin
                    n_fail++;
                    $display("FAIL random_sample_req: pos %0d got %b", p, sample_req);
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_volume();
        test_mute();
        test_sample_change();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
